hazard_unit_p: RTL and testbench
================================

# hazard_unit_p

Parametrised Tuse/Tnew hazard and forwarding unit for the 5-stage MIPS pipeline, successor to the fixed E/M/W hazard block. It resolves RAW hazards for `NRP` decode read ports against `NSTG` in-flight producer stages, plus a `HIST`-deep history of retired writes. It owns an internal multiply/divide busy counter and a saturating stall-cycle counter. It sits beside the pipeline registers and drives the PC, IF/ID and ID/EX enables and flushes.

## Interface
- `W`, 32, data width
- `NRP`, 2, decode read ports (≥1)
- `NSTG`, 3, producer stages after D, index 0 = youngest (E), `NSTG-1` = write-back (≥2)
- `HIST`, 1, retired-write history depth (≥1)
- `MUL_LAT`, 5, mult/multu busy cycles (1..15)
- `DIV_LAT`, 10, div/divu busy cycles (1..15)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset; asynchronous and active-low
- `d_addr`  in  NRP*5  register address per read port, port p at [5p+4:5p]
- `d_use`  in  NRP  port p reads GRF
- `d_tuse`  in  NRP*2  cycles after D until port p needs the operand
- `d_rdata`  in  NRP*W  raw GRF read data
- `d_md`  in  1  instruction in D uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- `s_waddr`  in  NSTG*5  destination per stage, 0 = no write
- `s_tnew`  in  NSTG*2  cycles until stage s result is valid; stage `NSTG-1` must be 0
- `s_wdata`  in  NSTG*W  result per stage, valid only when its tnew = 0
- `md_start`  in  1  one-cycle MDU start pulse from E
- `md_op`  in  1  0 = multiply, 1 = divide
- `fwd_d`  out  NRP*W  forwarded operand per port
- `en_pc`  out  1  PC write enable
- `en_ifid`  out  1  IF/ID enable
- `flush_idex`  out  1  insert bubble into ID/EX
- `md_busy`  out  1  MDU counter non-zero
- `stall_cnt`  out  32  total stall cycles, saturating

## Operation
- Match: stage s matches port p when `s_waddr[s] != 0` and `s_waddr[s] == d_addr[p]`. Only the youngest matching stage (lowest s) is considered.
- Port stall: `d_use[p]` and `d_addr[p] != 0` and youngest match has `s_tnew > d_tuse[p]`.
- Forwarding for port p, in priority order:
  - youngest matching stage with tnew = 0 -> its `s_wdata`;
  - else newest matching history entry (address ≠ 0) -> its data;
  - else `d_rdata[p]`.
- If the youngest match has tnew > 0, `fwd_d[p]` = `d_rdata[p]` (don't care; stall in effect). Address 0 always yields `d_rdata[p]`, which the GRF guarantees is 0.
- History: shift register of `HIST` {addr, data} entries. Each edge where `s_waddr[NSTG-1] != 0`, push {`s_waddr[NSTG-1]`, `s_wdata[NSTG-1]`} as newest; oldest drops. No push when the address is 0.
- MDU counter (4 bits):
  - `md_start` while counter = 0 loads `MUL_LAT` or `DIV_LAT` per `md_op`.
  - `md_start` while busy is ignored.
  - Otherwise the counter decrements when non-zero.
  - `md_busy = (cnt != 0)`.
- MD stall: `d_md && (md_busy || md_start)`.
- `stall = OR(port stalls) | MD stall`.
- Outputs from stall: `en_pc = en_ifid = ~stall`; `flush_idex = stall`.
- `stall_cnt` increments on each edge where stall = 1 and holds at 32'hFFFF_FFFF.

## Timing
- Stall, enables and `fwd_d` are purely combinational from current inputs and registered state; zero-cycle latency.
- `md_busy` rises the cycle after `md_start` and stays high exactly LAT cycles. MD stall covers the `md_start` cycle plus LAT cycles.
- A history entry becomes visible the cycle after its write-back edge. This bridges a same-cycle GRF write and read with no internal GRF bypass.
- Reset (asynchronous, `reset` = 0), all registered state cleared:
  - MDU counter = 0, so `md_busy` = 0;
  - `stall_cnt` = 0;
  - all history entries = {0, 0}.
- Combinational outputs during reset follow their equations with the cleared state.
- Reset mid-divide aborts the count immediately. An `md_start` coincident with reset is lost.
- Simultaneous push and read of the same address: the new entry is not visible until the next cycle; stage `NSTG-1` covers the current cycle.

## Test plan
- E stage: `s_waddr[0]`=8, tnew=1, data=X; D port 0 reads $8 with tuse=0 -> stall=1, en_pc=0, flush_idex=1. Next cycle E→M, tnew=0, data=32'h1234 -> stall=0, `fwd_d[0]`=32'h1234.
- Same address in E (tnew=0, 32'hAAAA) and M (tnew=0, 32'hBBBB) -> `fwd_d`=32'hAAAA. Same case with d_addr=0 -> `d_rdata`, no stall.
- Write-back $5=32'hCAFE at edge n, no other producers; D reads $5 at n+1 with `d_rdata`=0 -> `fwd_d`=32'hCAFE. With HIST=2, two later pushes to $6 and $7 evict $5 -> `d_rdata` returned.
- `md_start`, md_op=1, DIV_LAT=10; `d_md`=1 held -> stall asserted for 11 cycles, `md_busy` high for 10, `stall_cnt`=11. Second `md_start` mid-count is ignored.
- Drive reset low asynchronously mid-divide with `stall_cnt`=7 -> `md_busy`=0, `stall_cnt`=0, history cleared before the next clock edge.
- Force stall for 2^32+3 cycles (or preload via hierarchical force) -> `stall_cnt` saturates at 32'hFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/hazard_unit_p.sv
// Parametrised Tuse/Tnew hazard and forwarding unit: per-port RAW stall/forward
// resolution, retired-write history, MDU busy counter and saturating stall counter.
module hazard_unit_p #(
    parameter int W       = 32,
    parameter int NRP     = 2,
    parameter int NSTG    = 3,
    parameter int HIST    = 1,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*5-1:0]  d_addr,
    input  logic [NRP-1:0]    d_use,
    input  logic [NRP*2-1:0]  d_tuse,
    input  logic [NRP*W-1:0]  d_rdata,
    input  logic              d_md,
    input  logic [NSTG*5-1:0] s_waddr,
    input  logic [NSTG*2-1:0] s_tnew,
    input  logic [NSTG*W-1:0] s_wdata,
    input  logic              md_start,
    input  logic              md_op,
    output logic [NRP*W-1:0]  fwd_d,
    output logic              en_pc,
    output logic              en_ifid,
    output logic              flush_idex,
    output logic              md_busy,
    output logic [31:0]       stall_cnt
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    logic [4:0]   hist_addr [HIST];
    logic [W-1:0] hist_data [HIST];
    logic [3:0]   md_cnt;
    logic [NRP-1:0] port_stall;
    logic         stall;
    logic [4:0]   wb_addr;

    assign wb_addr = s_waddr[5*(NSTG-1) +: 5];

    always_comb begin : fwd_logic
        logic [4:0]   addr;
        logic         hit;
        logic [1:0]   hit_tnew;
        logic [W-1:0] hit_data;
        logic         hhit;
        logic [W-1:0] hhit_data;
        port_stall = '0;
        fwd_d      = '0;
        addr       = '0;
        hit        = 1'b0;
        hit_tnew   = '0;
        hit_data   = '0;
        hhit       = 1'b0;
        hhit_data  = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            addr     = d_addr[5*p +: 5];
            hit      = 1'b0;
            hit_tnew = '0;
            hit_data = '0;
            hhit     = 1'b0;
            hhit_data = '0;
            // Scan oldest to youngest so the youngest match is the one that sticks.
            for (int unsigned i = 0; i < NSTG; i++) begin
                if (s_waddr[5*(NSTG-1-i) +: 5] != 5'd0 &&
                    s_waddr[5*(NSTG-1-i) +: 5] == addr) begin
                    hit      = 1'b1;
                    hit_tnew = s_tnew[2*(NSTG-1-i) +: 2];
                    hit_data = s_wdata[W*(NSTG-1-i) +: W];
                end
            end
            for (int unsigned i = 0; i < HIST; i++) begin
                if (hist_addr[HIST-1-i] != 5'd0 && hist_addr[HIST-1-i] == addr) begin
                    hhit      = 1'b1;
                    hhit_data = hist_data[HIST-1-i];
                end
            end
            fwd_d[W*p +: W] = d_rdata[W*p +: W];
            if (hit) begin
                if (hit_tnew == 2'd0)
                    fwd_d[W*p +: W] = hit_data;
            end else if (hhit) begin
                fwd_d[W*p +: W] = hhit_data;
            end
            port_stall[p] = d_use[p] && (addr != 5'd0) && hit &&
                            (hit_tnew > d_tuse[2*p +: 2]);
        end
    end

    assign md_busy    = (md_cnt != 4'd0);
    assign stall      = (|port_stall) || (d_md && (md_busy || md_start));
    assign en_pc      = ~stall;
    assign en_ifid    = ~stall;
    assign flush_idex = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_start && md_cnt == 4'd0) begin
            md_cnt <= md_op ? DIV_CNT : MUL_CNT;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < HIST; i++) begin
                hist_addr[i] <= '0;
                hist_data[i] <= '0;
            end
        end else if (wb_addr != 5'd0) begin
            hist_addr[0] <= wb_addr;
            hist_data[0] <= s_wdata[W*(NSTG-1) +: W];
            for (int unsigned i = 1; i < HIST; i++) begin
                hist_addr[i] <= hist_addr[i-1];
                hist_data[i] <= hist_data[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Self-checking bench for hazard_unit_p: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_hazard_unit_p;

    localparam int W       = 32;
    localparam int NRP     = 2;
    localparam int NSTG    = 3;
    localparam int HIST    = 2;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic              clk;
    logic              reset;
    logic [NRP*5-1:0]  d_addr;
    logic [NRP-1:0]    d_use;
    logic [NRP*2-1:0]  d_tuse;
    logic [NRP*W-1:0]  d_rdata;
    logic              d_md;
    logic [NSTG*5-1:0] s_waddr;
    logic [NSTG*2-1:0] s_tnew;
    logic [NSTG*W-1:0] s_wdata;
    logic              md_start;
    logic              md_op;
    logic [NRP*W-1:0]  fwd_d;
    logic              en_pc;
    logic              en_ifid;
    logic              flush_idex;
    logic              md_busy;
    logic [31:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_unit_p #(
        .W(W), .NRP(NRP), .NSTG(NSTG), .HIST(HIST), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .d_addr(d_addr), .d_use(d_use), .d_tuse(d_tuse),
        .d_rdata(d_rdata), .d_md(d_md), .s_waddr(s_waddr), .s_tnew(s_tnew),
        .s_wdata(s_wdata), .md_start(md_start), .md_op(md_op), .fwd_d(fwd_d),
        .en_pc(en_pc), .en_ifid(en_ifid), .flush_idex(flush_idex), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history as a queue (front = newest), MDU busy as a cycle window.
    longint       cyc     = 0;
    longint       md_last = -1;
    longint       exp_cnt = 0;
    logic [4:0]   hq_addr [$];
    logic [W-1:0] hq_data [$];

    function automatic logic m_busy();
        return cyc <= md_last;
    endfunction

    function automatic logic m_stall();
        logic st;
        logic found;
        logic [4:0] a;
        st = d_md && (m_busy() || md_start);
        for (int p = 0; p < NRP; p++) begin
            a = d_addr[5*p +: 5];
            found = 1'b0;
            for (int s = 0; s < NSTG; s++) begin
                if (!found && s_waddr[5*s +: 5] == a && a != 5'd0) begin
                    found = 1'b1;
                    if (d_use[p] && s_tnew[2*s +: 2] > d_tuse[2*p +: 2]) st = 1'b1;
                end
            end
        end
        return st;
    endfunction

    function automatic logic [W-1:0] m_fwd(int p);
        logic [4:0] a;
        a = d_addr[5*p +: 5];
        if (a == 5'd0) return d_rdata[W*p +: W];
        for (int s = 0; s < NSTG; s++)
            if (s_waddr[5*s +: 5] == a)
                return (s_tnew[2*s +: 2] == 2'd0) ? s_wdata[W*s +: W] : d_rdata[W*p +: W];
        foreach (hq_addr[i])
            if (hq_addr[i] == a) return hq_data[i];
        return d_rdata[W*p +: W];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hq_addr.delete();
            hq_data.delete();
            md_last = -1;
            exp_cnt = 0;
        end else begin
            if (m_stall() && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
            if (md_start && !m_busy()) md_last = cyc + longint'(md_op ? DIV_LAT : MUL_LAT);
            if (s_waddr[5*(NSTG-1) +: 5] != 5'd0) begin
                hq_addr.push_front(s_waddr[5*(NSTG-1) +: 5]);
                hq_data.push_front(s_wdata[W*(NSTG-1) +: W]);
                if (hq_addr.size() > HIST) begin
                    void'(hq_addr.pop_back());
                    void'(hq_data.pop_back());
                end
            end
            cyc++;
        end
    end

    task automatic clear_in();
        d_addr = '0; d_use = '0; d_tuse = '0; d_rdata = '0; d_md = 1'b0;
        s_waddr = '0; s_tnew = '0; s_wdata = '0; md_start = 1'b0; md_op = 1'b0;
    endtask

    task automatic set_stage(int s, logic [4:0] a, logic [1:0] t, logic [W-1:0] d);
        s_waddr[5*s +: 5] = a;
        s_tnew[2*s +: 2]  = t;
        s_wdata[W*s +: W] = d;
    endtask

    task automatic set_port(int p, logic [4:0] a, logic u, logic [1:0] t, logic [W-1:0] rd);
        d_addr[5*p +: 5]  = a;
        d_use[p]          = u;
        d_tuse[2*p +: 2]  = t;
        d_rdata[W*p +: W] = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b0;
        @(negedge clk);
        set_port(0, 5'd3, 1'b0, 2'd0, 32'h1234_5678);
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b expected 0", md_busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL reset_en_pc: got %b expected 1", en_pc); end
        checks++; if (fwd_d[W-1:0] !== 32'h1234_5678) begin errors++; $display("FAIL reset_fwd: got %h expected 12345678", fwd_d[W-1:0]); end
        set_stage(0, 5'd3, 2'd2, 32'h0);
        set_port(0, 5'd3, 1'b1, 2'd0, 32'h0);
        #1;
        checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL reset_comb_stall: got %b expected 1", flush_idex); end
        @(negedge clk);
        clear_in();
        reset = 1'b1;
    endtask

    task automatic test_stall_fwd();
        @(negedge clk); clear_in();
        set_stage(0, 5'd8, 2'd1, 32'hDEAD_BEEF);
        set_port(0, 5'd8, 1'b1, 2'd0, 32'h0);
        #1;
        checks++; if (en_pc !== 1'b0) begin errors++; $display("FAIL raw_en_pc: got %b expected 0", en_pc); end
        checks++; if (en_ifid !== 1'b0) begin errors++; $display("FAIL raw_en_ifid: got %b expected 0", en_ifid); end
        checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL raw_flush: got %b expected 1", flush_idex); end
        @(negedge clk); clear_in();
        set_stage(1, 5'd8, 2'd0, 32'h1234);
        set_port(0, 5'd8, 1'b1, 2'd0, 32'h0);
        #1;
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL fwd_en_pc: got %b expected 1", en_pc); end
        checks++; if (fwd_d[W-1:0] !== 32'h1234) begin errors++; $display("FAIL fwd_m_data: got %h expected 1234", fwd_d[W-1:0]); end
        // tnew == tuse is just in time; one more cycle of tnew stalls
        @(negedge clk); clear_in();
        set_stage(0, 5'd9, 2'd2, 32'h0);
        set_port(1, 5'd9, 1'b1, 2'd2, 32'h0);
        #1;
        checks++; if (flush_idex !== 1'b0) begin errors++; $display("FAIL tuse_eq_tnew: got %b expected 0", flush_idex); end
        set_port(1, 5'd9, 1'b1, 2'd1, 32'h0);
        #1;
        checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL tuse_lt_tnew: got %b expected 1", flush_idex); end
        set_port(1, 5'd9, 1'b0, 2'd1, 32'h0);
        #1;
        checks++; if (flush_idex !== 1'b0) begin errors++; $display("FAIL unused_port: got %b expected 0", flush_idex); end
    endtask

    task automatic test_priority();
        @(negedge clk); clear_in();
        set_stage(0, 5'd10, 2'd0, 32'hAAAA);
        set_stage(1, 5'd10, 2'd0, 32'hBBBB);
        set_port(0, 5'd10, 1'b1, 2'd0, 32'h0);
        set_port(1, 5'd0, 1'b1, 2'd0, 32'h5555);
        #1;
        checks++; if (fwd_d[W-1:0] !== 32'hAAAA) begin errors++; $display("FAIL prio_youngest: got %h expected aaaa", fwd_d[W-1:0]); end
        checks++; if (fwd_d[2*W-1:W] !== 32'h5555) begin errors++; $display("FAIL prio_addr0: got %h expected 5555", fwd_d[2*W-1:W]); end
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL prio_no_stall: got %b expected 1", en_pc); end
        set_stage(0, 5'd10, 2'd1, 32'hAAAA);
        set_port(0, 5'd10, 1'b1, 2'd1, 32'h77);
        #1;
        checks++; if (fwd_d[W-1:0] !== 32'h77) begin errors++; $display("FAIL prio_young_pending: got %h expected 77", fwd_d[W-1:0]); end
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL prio_pending_stall: got %b expected 1", en_pc); end
    endtask

    task automatic test_history();
        do_reset();
        @(negedge clk); clear_in();
        set_stage(2, 5'd5, 2'd0, 32'hCAFE);
        @(negedge clk); clear_in();
        set_port(0, 5'd5, 1'b1, 2'd0, 32'h0);
        #1;
        checks++; if (fwd_d[W-1:0] !== 32'hCAFE) begin errors++; $display("FAIL hist_hit: got %h expected cafe", fwd_d[W-1:0]); end
        @(negedge clk); clear_in();
        set_port(0, 5'd5, 1'b1, 2'd0, 32'h0);
        set_stage(2, 5'd6, 2'd0, 32'h6666);
        @(negedge clk); clear_in();
        set_port(0, 5'd5, 1'b1, 2'd0, 32'h0);
        set_port(1, 5'd7, 1'b1, 2'd0, 32'h0);
        set_stage(2, 5'd7, 2'd0, 32'h7777);
        #1;
        checks++; if (fwd_d[W-1:0] !== 32'hCAFE) begin errors++; $display("FAIL hist_depth2: got %h expected cafe", fwd_d[W-1:0]); end
        checks++; if (fwd_d[2*W-1:W] !== 32'h7777) begin errors++; $display("FAIL hist_same_cycle_wb: got %h expected 7777", fwd_d[2*W-1:W]); end
        @(negedge clk); clear_in();
        set_port(0, 5'd5, 1'b1, 2'd0, 32'h1111);
        set_port(1, 5'd6, 1'b1, 2'd0, 32'h0);
        #1;
        checks++; if (fwd_d[W-1:0] !== 32'h1111) begin errors++; $display("FAIL hist_evict: got %h expected 1111", fwd_d[W-1:0]); end
        checks++; if (fwd_d[2*W-1:W] !== 32'h6666) begin errors++; $display("FAIL hist_older: got %h expected 6666", fwd_d[2*W-1:W]); end
    endtask

    task automatic test_mdu();
        int busy_cycles;
        do_reset();
        @(negedge clk); clear_in();
        d_md = 1'b1; md_start = 1'b1; md_op = 1'b1;
        #1;
        checks++; if (en_pc !== 1'b0) begin errors++; $display("FAIL md_start_stall: got %b expected 0", en_pc); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_start_busy: got %b expected 0", md_busy); end
        for (int i = 1; i <= DIV_LAT; i++) begin
            @(negedge clk); clear_in();
            d_md = 1'b1;
            md_start = (i == 4);
            #1;
            checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_%0d: got %b expected 1", i, md_busy); end
            checks++; if (flush_idex !== 1'b1) begin errors++; $display("FAIL div_stall_%0d: got %b expected 1", i, flush_idex); end
        end
        @(negedge clk); clear_in();
        d_md = 1'b1;
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_done: got %b expected 0", md_busy); end
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL div_release: got %b expected 1", en_pc); end
        checks++; if (stall_cnt !== 32'd11) begin errors++; $display("FAIL div_stall_cnt: got %0d expected 11", stall_cnt); end
        @(negedge clk); clear_in();
        md_start = 1'b1;
        #1;
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL mul_no_dmd: got %b expected 1", en_pc); end
        @(negedge clk); clear_in();
        busy_cycles = 0;
        for (int i = 0; i < 20 && md_busy; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        checks++; if (busy_cycles != MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", busy_cycles, MUL_LAT); end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); clear_in();
        set_stage(2, 5'd9, 2'd0, 32'h99);
        @(negedge clk); clear_in();
        d_md = 1'b1; md_start = 1'b1; md_op = 1'b1;
        repeat (6) begin
            @(negedge clk); clear_in();
            d_md = 1'b1;
        end
        @(negedge clk); clear_in();
        d_md = 1'b1;
        set_port(0, 5'd9, 1'b0, 2'd0, 32'h0);
        #1;
        checks++; if (stall_cnt !== 32'd7) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 7", stall_cnt); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b expected 1", md_busy); end
        checks++; if (fwd_d[W-1:0] !== 32'h99) begin errors++; $display("FAIL pre_reset_hist: got %h expected 99", fwd_d[W-1:0]); end
        #2 reset = 1'b0;
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", md_busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL async_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (fwd_d[W-1:0] !== 32'h0) begin errors++; $display("FAIL async_hist: got %h expected 0", fwd_d[W-1:0]); end
        checks++; if (en_pc !== 1'b1) begin errors++; $display("FAIL async_en_pc: got %b expected 1", en_pc); end
        @(negedge clk);
        reset = 1'b1;
        clear_in();
    endtask

    task automatic test_saturate();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'hFFFF_FFFE;
        exp_tab[1] = 32'hFFFF_FFFF;
        exp_tab[2] = 32'hFFFF_FFFF;
        exp_tab[3] = 32'hFFFF_FFFF;
        do_reset();
        @(negedge clk); clear_in();
        set_stage(0, 5'd4, 2'd3, 32'h0);
        set_port(0, 5'd4, 1'b1, 2'd0, 32'h0);
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (stall_cnt !== exp_tab[i]) begin errors++; $display("FAIL saturate_%0d: got %h expected %h", i, stall_cnt, exp_tab[i]); end
        end
    endtask

    task automatic test_random();
        logic exp_st;
        do_reset();
        repeat (500) begin
            @(negedge clk); clear_in();
            for (int p = 0; p < NRP; p++)
                set_port(p, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), $urandom);
            for (int s = 0; s < NSTG; s++)
                set_stage(s, 5'($urandom_range(0, 7)),
                          (s == NSTG-1) ? 2'd0 : 2'($urandom_range(0, 3)), $urandom);
            d_md     = ($urandom_range(0, 3) == 0);
            md_start = ($urandom_range(0, 7) == 0);
            md_op    = 1'($urandom_range(0, 1));
            #1;
            exp_st = m_stall();
            for (int p = 0; p < NRP; p++) begin
                checks++; if (fwd_d[W*p +: W] !== m_fwd(p)) begin errors++; $display("FAIL rand_fwd%0d: got %h expected %h", p, fwd_d[W*p +: W], m_fwd(p)); end
            end
            checks++; if (en_pc !== !exp_st) begin errors++; $display("FAIL rand_en_pc: got %b expected %b", en_pc, !exp_st); end
            checks++; if (en_ifid !== !exp_st) begin errors++; $display("FAIL rand_en_ifid: got %b expected %b", en_ifid, !exp_st); end
            checks++; if (flush_idex !== exp_st) begin errors++; $display("FAIL rand_flush: got %b expected %b", flush_idex, exp_st); end
            checks++; if (md_busy !== m_busy()) begin errors++; $display("FAIL rand_md_busy: got %b expected %b", md_busy, m_busy()); end
            checks++; if (stall_cnt !== exp_cnt[31:0]) begin errors++; $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt[31:0]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_in();
        test_reset();
        test_stall_fwd();
        test_priority();
        test_history();
        test_mdu();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
